// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: single-cycle ALU ops plus iterative multiply/divide,
// with a back-pressured result register. Optional flush port via `define EX_FLUSH_EN.
module ex_stage_mc #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EX_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] pc,
  input  logic             alu_src,
  input  logic [3:0]       alu_func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] pc_out,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic             ovf_q, ovf_d;

  logic             flush_act;
  logic             accept;
  logic [WIDTH-1:0] b;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sum, diff, pc_tgt;
  logic [WIDTH-1:0] sc_res, mc_res;
  logic             sc_ovf;
  logic             is_mc, is_mul, div_signed, a_neg, b_neg;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

`ifdef EX_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  assign b          = alu_src ? immediate : rs2;
  assign shamt      = b[SW-1:0];
  assign sum        = rs1 + b;
  assign diff       = rs1 - b;
  assign pc_tgt     = pc + (immediate << IMM_SHIFT);
  assign is_mc      = alu_func[3] & (alu_func[2] | alu_func[1]);
  assign is_mul     = (alu_func[3:1] == 3'b101);
  assign div_signed = (alu_func[3:2] == 2'b11) & ~alu_func[0];
  assign a_neg      = div_signed & rs1[WIDTH-1];
  assign b_neg      = div_signed & b[WIDTH-1];

  assign in_ready = ((state_q == StIdle) | ((state_q == StDone) & out_ready)) & ~flush_act;
  assign accept   = in_valid & in_ready;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    unique case (alu_func)
      4'd0: begin
        sc_res = sum;
        sc_ovf = (rs1[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != rs1[WIDTH-1]);
      end
      4'd1: begin
        sc_res = diff;
        sc_ovf = (rs1[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != rs1[WIDTH-1]);
      end
      4'd2:    sc_res = rs1 & b;
      4'd3:    sc_res = rs1 | b;
      4'd4:    sc_res = rs1 ^ b;
      4'd5:    sc_res = rs1 << shamt;
      4'd6:    sc_res = rs1 >> shamt;
      4'd7:    sc_res = $signed(rs1) >>> shamt;
      4'd8:    sc_res = {{(WIDTH-1){1'b0}}, $signed(rs1) < $signed(b)};
      4'd9:    sc_res = {{(WIDTH-1){1'b0}}, rs1 < b};
      default: sc_res = '0;
    endcase
  end

  // Iteration datapaths: shift-add multiply keeps {acc, mq} as the growing product;
  // restoring divide keeps acc as partial remainder and shifts the quotient into mq.
  assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
  assign div_shift = {acc_q, mq_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};

  always_comb begin
    mc_res = '0;
    unique case (op_q)
      4'd10:        mc_res = mq_q;
      4'd11:        mc_res = acc_q;
      4'd12, 4'd13: mc_res = div_zero_q ? '1 : (q_neg_q ? -mq_q : mq_q);
      4'd14, 4'd15: mc_res = r_neg_q ? -acc_q : acc_q;
      default:      mc_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    mcand_d    = mcand_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_zero_d = div_zero_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    pc_out_d   = pc_out_q;
    ovf_d      = ovf_q;

    if (flush_act) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            data2_d  = rs2;
            pc_out_d = pc_tgt;
            if (is_mc) begin
              state_d    = StBusy;
              cnt_d      = CW'(WIDTH);
              op_d       = alu_func;
              acc_d      = '0;
              mq_d       = (is_mul || !a_neg) ? rs1 : -rs1;
              mcand_d    = (is_mul || !b_neg) ? b : -b;
              q_neg_d    = a_neg ^ b_neg;
              r_neg_d    = a_neg;
              div_zero_d = (b == '0);
            end else begin
              state_d = StDone;
              data1_d = sc_res;
              ovf_d   = sc_ovf;
            end
          end else if (state_q == StDone && out_ready) begin
            state_d = StIdle;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (op_q[3:1] == 3'b101) begin
              acc_d = mul_sum[WIDTH:1];
              mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
              acc_d = div_diff[WIDTH-1:0];
              mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = div_shift[WIDTH-1:0];
              mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            state_d = StDone;
            data1_d = mc_res;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      mcand_q    <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      data1_q    <= '0;
      data2_q    <= '0;
      pc_out_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      mcand_q    <= mcand_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div_zero_q <= div_zero_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      pc_out_q   <= pc_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign data1     = data1_q;
  assign data2     = data2_q;
  assign pc_out    = pc_out_q;
  assign zero      = (data1_q == '0);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed-vector bench for ex_stage_mc (WIDTH=32); covers flush when EX_FLUSH_EN is defined.
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] rs1, rs2, immediate, pc;
  logic        alu_src;
  logic [3:0]  alu_func;
  logic        out_valid, out_ready;
  logic [31:0] data1, data2, pc_out;
  logic        zero, overflow;
`ifdef EX_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ex_stage_mc #(.WIDTH(32), .IMM_SHIFT(1)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef EX_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .immediate (immediate),
    .pc        (pc),
    .alu_src   (alu_src),
    .alu_func  (alu_func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data1     (data1),
    .data2     (data2),
    .pc_out    (pc_out),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] bb);
    alu_func = f;
    rs1      = a;
    rs2      = bb;
    alu_src  = 1'b0;
  endtask

  // Single-cycle op: result must be visible right after the accepting edge.
  task automatic run_sc(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] bb, input logic [31:0] exp, input logic ovf);
    out_ready = 1'b1;
    set_op(f, a, bb);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, data1, exp);
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    step();
  endtask

  // Multi-cycle op: out_valid must rise exactly 33 cycles after accept, in_ready low meanwhile.
  task automatic run_mc(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] bb, input logic [31:0] exp);
    int cycles;
    logic rdy_seen;
    out_ready = 1'b1;
    set_op(f, a, bb);
    pc        = 32'h40;
    immediate = 32'h8;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    cycles   = 0;
    rdy_seen = 1'b0;
    while (!out_valid && cycles < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      cycles++;
    end
    check({tag, "_lat"}, cycles, 32'd33);
    check({tag, "_busy_rdy"}, {31'd0, rdy_seen}, 32'd0);
    check(tag, data1, exp);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check({tag, "_pc"}, pc_out, 32'h50);
    check({tag, "_d2"}, data2, bb);
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs1 = '0; rs2 = '0; immediate = '0; pc = '0; alu_src = 1'b0; alu_func = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d1", data1, 32'd0);
    check("rst_d2", data2, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops at full throughput
    out_ready = 1'b1;
    set_op(4'd0, 32'h7FFF_FFFF, 32'd1);
    in_valid = 1'b1;
    step();
    check("b2b_add", data1, 32'h8000_0000);
    check("b2b_add_ovf", {31'd0, overflow}, 32'd1);
    check("b2b_add_zero", {31'd0, zero}, 32'd0);
    check("b2b_rdy", {31'd0, in_ready}, 32'd1);
    set_op(4'd1, 32'd5, 32'd5);
    step();
    check("b2b_sub", data1, 32'd0);
    check("b2b_sub_zero", {31'd0, zero}, 32'd1);
    check("b2b_sub_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Immediate operand and branch target
    set_op(4'd0, 32'h20, 32'h0000_ABCD);
    alu_src = 1'b1; immediate = 32'hFFFF_FFF8; pc = 32'h100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("imm_add", data1, 32'h18);
    check("imm_pc", pc_out, 32'hF0);
    check("imm_d2", data2, 32'h0000_ABCD);
    check("imm_ovf", {31'd0, overflow}, 32'd0);
    step();

    run_sc("and", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    run_sc("or", 4'd3, 32'h12, 32'h21, 32'h33, 1'b0);
    run_sc("xor", 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0);
    run_sc("sll", 4'd5, 32'h3, 32'h24, 32'h30, 1'b0);
    run_sc("srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    run_sc("sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    run_sc("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    run_sc("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    run_sc("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);

    run_mc("mul", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    run_mc("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mc("mul_small", 4'd10, 32'd1234, 32'd567, 32'd699678);
    run_mc("div", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_mc("rem", 4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_mc("divu_z", 4'd13, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_mc("rem_z", 4'd14, 32'd13, 32'd0, 32'd13);
    run_mc("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mc("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_mc("divu", 4'd13, 32'd100, 32'd7, 32'd14);
    run_mc("remu", 4'd15, 32'd100, 32'd7, 32'd2);

    // Back-pressure: held result, then same-cycle release and accept
    out_ready = 1'b0;
    set_op(4'd0, 32'd3, 32'd4);
    in_valid = 1'b1;
    step();
    set_op(4'd3, 32'hF0, 32'h0F);
    for (int i = 0; i < 5; i++) begin
      check("bp_d1", data1, 32'd7);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_rdy", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_next", data1, 32'hFF);
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    step();

    // Reset during BUSY abandons the operation
    set_op(4'd13, 32'd100, 32'd7);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstb_valid", {31'd0, out_valid}, 32'd0);
    check("rstb_rdy", {31'd0, in_ready}, 32'd1);
    check("rstb_d1", data1, 32'd0);
    check("rstb_zero", {31'd0, zero}, 32'd1);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid) seen = 1'b1;
        step();
      end
      check("rstb_no_out", {31'd0, seen}, 32'd0);
    end

`ifdef EX_FLUSH_EN
    run_sc("fl_pre", 4'd0, 32'd3, 32'd4, 32'd7, 1'b0);
    set_op(4'd13, 32'd100, 32'd7);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    #1;
    check("fl_rdy_during", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_rdy", {31'd0, in_ready}, 32'd1);
    check("fl_d1", data1, 32'd7);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid) seen = 1'b1;
        step();
      end
      check("fl_no_out", {31'd0, seen}, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
Parametrised execute stage for the RISC-V pipeline, replacing the single-cycle EX stage.
- Accepts one operation per valid/ready handshake.
- Single-cycle ALU ops complete in one cycle; iterative RV32M-style multiply/divide ops take multiple cycles.
- Computes the branch target pc + (imm << 1) alongside the result.
- Holds the result in an output register that back-pressures the upstream pipeline.

Parameters:
WIDTH, 32, datapath width in bits (>= 8).
IMM_SHIFT, 1, left shift applied to immediate before adding to pc for branch target.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  stage can accept operation this cycle
rs1  input  WIDTH  operand A
rs2  input  WIDTH  operand B register value
immediate  input  WIDTH  immediate operand
pc  input  WIDTH  instruction pc
alu_src  input  1  1: B = immediate, 0: B = rs2
alu_func  input  4  operation code (see Behaviour)
out_valid  output  1  result register holds valid data
out_ready  input  1  downstream accepts result
data1  output  WIDTH  operation result
data2  output  WIDTH  captured rs2 (store data)
pc_out  output  WIDTH  branch target
zero  output  1  data1 == 0
overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA, using shift amount B[log2(WIDTH)-1:0].
  - 8 SLT, 9 SLTU.
  - 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned).
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Codes 0-9 are single-cycle; codes 10-15 are multi-cycle.
- FSM states:
  - IDLE: no op held.
  - BUSY: iterating a multi-cycle op.
  - DONE: result held, out_valid=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). DONE with out_ready=1 allows back-to-back accept, giving full throughput for single-cycle ops.
- Accept occurs when in_valid & in_ready:
  - Single-cycle op: result, flags, pc_out and data2 registered; state -> DONE; out_valid=1 on the next cycle (latency 1).
  - Multi-cycle op: operands and op captured; state -> BUSY; counter loaded with WIDTH.
- BUSY:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements.
  - When counter reaches 0, result is written and state -> DONE. out_valid rises WIDTH+1 cycles after accept.
  - in_ready=0 throughout.
- pc_out and data2 are captured at accept and held unchanged through BUSY and DONE.
- DONE:
  - Outputs stable while out_ready=0.
  - out_ready=1 with no new accept -> IDLE, out_valid=0 next cycle.
- Divide corner cases (RISC-V semantics):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - Signed DIV of most-negative by -1: quotient = most-negative, REM = 0, no trap.
  - Both corner cases complete in the same WIDTH+1 latency.
- Signed DIV/REM: magnitudes are divided and the sign is fixed up on the final step. REM takes the dividend's sign.
- Arithmetic wraps modulo 2^WIDTH. pc_out = pc + (immediate << IMM_SHIFT), wrapping.
- zero is computed from the final data1 value for every op.
- Reset: state IDLE; out_valid=0; data1, data2, pc_out all 0; zero=1; overflow=0; counter 0; in_ready=1 the cycle after reset deasserts.
- Reset asserted mid-BUSY or in DONE abandons the operation; no output is produced.
- in_valid while not in_ready is ignored; upstream must hold the operation.

Optional Feature:
EX_FLUSH_EN:
- Defined: adds input port flush (1 bit).
  - flush=1 forces state -> IDLE and out_valid=0 next cycle, aborting BUSY or dropping a held result.
  - in_ready=0 during a flush cycle, so no accept occurs that cycle.
  - Data registers keep their last values.
- Undefined: no flush port; only rst aborts an operation.

Test Plan:
1. Back-to-back ADD, WIDTH=32, out_ready=1: rs1=0x7FFFFFFF, B=1 -> data1=0x80000000, overflow=1, zero=0. Next op SUB 5-5 -> data1=0, zero=1. One result per cycle, latency 1.
2. alu_src=1, immediate=0xFFFFFFF8 (-8), pc=0x100, op ADD rs1=0x20 -> data1=0x18, pc_out=0xF0, data2=rs2.
3. MUL 0xFFFFFFFF*0xFFFFFFFF -> data1=1. MULHU of same -> 0xFFFFFFFE. out_valid exactly 33 cycles after accept; in_ready=0 while BUSY.
4. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU x/0 -> 0xFFFFFFFF. REM 13/0 -> 13. DIV 0x80000000/-1 -> 0x80000000.
5. Back-pressure: result in DONE, out_ready=0 for 5 cycles -> data1/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new op accepted that same cycle.
6. Assert rst during cycle 10 of a DIVU -> next cycle out_valid=0, in_ready=1, data1=0, zero=1. With EX_FLUSH_EN, flush mid-BUSY -> same state/valid result; data1 retains its previous value.
